aer_sample_sequencer: RTL and testbench

AER_SAMPLE_SEQUENCER -- requirements
Module: aer_sample_sequencer

---
 rtl/aer_sample_sequencer.sv | 173 +++++++++++++++++
 tb/tb_aer_sample_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_sample_sequencer.sv
// Feeds source AER events to the core over a 4-phase REQ/ACK link, inserting
// all-ones time-step markers, then waits for the core to finish the sample.
module aer_sample_sequencer #(
  parameter int AER_WIDTH   = 12,
  parameter int TIME_STEP   = 8,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         IS_POS_IN,
  input  logic                         IS_TRAIN_IN,
  input  logic                         EV_VALID,
  input  logic [AER_WIDTH-1:0]         EV_ADDR,
  input  logic                         EV_LAST,
  output logic                         EV_READY,
  output logic [AER_WIDTH-1:0]         AERIN_ADDR,
  output logic                         AERIN_REQ,
  input  logic                         AERIN_ACK,
  output logic                         IS_POS,
  output logic                         IS_TRAIN,
  input  logic                         ONE_SAMPLE_FINISH,
  input  logic [31:0]                  GOODNESS,
  output logic [31:0]                  GOODNESS_OUT,
  output logic [$clog2(TIME_STEP):0]   TS_CNT,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERR
);

  localparam int TSW = $clog2(TIME_STEP) + 1;
  localparam logic [AER_WIDTH-1:0] MARKER   = '1;
  localparam logic [TSW-1:0]       TS_LAST  = TSW'(TIME_STEP);
  localparam logic [9:0]           WD_LIMIT = 10'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, FETCH, REQ, ACKLO, MREQ, MACKLO, WAIT_FIN
  } state_t;

  state_t               state_reg, state_next;
  logic [AER_WIDTH-1:0] addr_reg, addr_next;
  logic                 last_reg, last_next;
  logic                 req_reg, req_next;
  logic [TSW-1:0]       ts_cnt_reg, ts_cnt_next;
  logic [TSW-1:0]       ts_inc;
  logic [9:0]           wd_cnt_reg, wd_cnt_next;
  logic                 wd_expire;
  logic                 err_reg, err_next;
  logic                 done_reg, done_next;
  logic [31:0]          goodness_reg, goodness_next;
  logic                 is_pos_reg, is_pos_next;
  logic                 is_train_reg, is_train_next;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      last_reg     <= 1'b0;
      req_reg      <= 1'b0;
      ts_cnt_reg   <= '0;
      wd_cnt_reg   <= '0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
      goodness_reg <= '0;
      is_pos_reg   <= 1'b0;
      is_train_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      last_reg     <= last_next;
      req_reg      <= req_next;
      ts_cnt_reg   <= ts_cnt_next;
      wd_cnt_reg   <= wd_cnt_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
      goodness_reg <= goodness_next;
      is_pos_reg   <= is_pos_next;
      is_train_reg <= is_train_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    last_next     = last_reg;
    ts_cnt_next   = ts_cnt_reg;
    err_next      = err_reg;
    done_next     = 1'b0;
    goodness_next = goodness_reg;
    is_pos_next   = is_pos_reg;
    is_train_next = is_train_reg;
    ts_inc        = ts_cnt_reg + TSW'(1);
    // Expires on the cycle the count would reach the limit, so REQ stays high exactly ACK_TIMEOUT cycles.
    wd_expire     = (wd_cnt_reg + 10'd1) == WD_LIMIT;

    case (state_reg)
      IDLE: begin
        if (START) begin
          is_pos_next   = IS_POS_IN;
          is_train_next = IS_TRAIN_IN;
          ts_cnt_next   = '0;
          err_next      = 1'b0;
          state_next    = FETCH;
        end
      end
      FETCH: begin
        if (EV_VALID) begin
          last_next = EV_LAST;
          if (EV_ADDR != MARKER) begin
            addr_next  = EV_ADDR;
            state_next = REQ;
          end else if (EV_LAST) begin
            addr_next  = MARKER;
            state_next = MREQ;
          end
        end
      end
      REQ, MREQ: begin
        if (AERIN_ACK) begin
          state_next = (state_reg == REQ) ? ACKLO : MACKLO;
        end else if (wd_expire) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      ACKLO: begin
        if (!AERIN_ACK) begin
          if (last_reg) begin
            addr_next  = MARKER;
            state_next = MREQ;
          end else begin
            state_next = FETCH;
          end
        end else if (wd_expire) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      MACKLO: begin
        if (!AERIN_ACK) begin
          ts_cnt_next = ts_inc;
          state_next  = (ts_inc == TS_LAST) ? WAIT_FIN : FETCH;
        end else if (wd_expire) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_FIN: begin
        if (ONE_SAMPLE_FINISH) begin
          goodness_next = GOODNESS;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    req_next    = (state_next == REQ) || (state_next == MREQ);
    wd_cnt_next = (state_next != state_reg) ? 10'd0 : wd_cnt_reg + 10'd1;
  end

  assign EV_READY     = (state_reg == FETCH);
  assign BUSY         = (state_reg != IDLE);
  assign AERIN_ADDR   = addr_reg;
  assign AERIN_REQ    = req_reg;
  assign TS_CNT       = ts_cnt_reg;
  assign ERR          = err_reg;
  assign DONE         = done_reg;
  assign GOODNESS_OUT = goodness_reg;
  assign IS_POS       = is_pos_reg;
  assign IS_TRAIN     = is_train_reg;

endmodule

// File: tb/tb_aer_sample_sequencer.sv
// Directed bench: a table of full-sample scenarios plus hand-written timeout,
// reset-mid-handshake and ignored-input sequences, against a 2-cycle-delay core model.
module tb_aer_sample_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        IS_POS_IN = 1'b0;
  logic        IS_TRAIN_IN = 1'b0;
  logic        EV_VALID = 1'b0;
  logic [11:0] EV_ADDR = '0;
  logic        EV_LAST = 1'b0;
  logic        EV_READY;
  logic [11:0] AERIN_ADDR;
  logic        AERIN_REQ;
  logic        AERIN_ACK = 1'b0;
  logic        IS_POS, IS_TRAIN;
  logic        ONE_SAMPLE_FINISH = 1'b0;
  logic [31:0] GOODNESS = '0;
  logic [31:0] GOODNESS_OUT;
  logic [3:0]  TS_CNT;
  logic        BUSY, DONE, ERR;

  aer_sample_sequencer #(.AER_WIDTH(12), .TIME_STEP(8), .ACK_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IS_POS_IN(IS_POS_IN), .IS_TRAIN_IN(IS_TRAIN_IN),
    .EV_VALID(EV_VALID), .EV_ADDR(EV_ADDR), .EV_LAST(EV_LAST), .EV_READY(EV_READY),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .IS_POS(IS_POS), .IS_TRAIN(IS_TRAIN), .ONE_SAMPLE_FINISH(ONE_SAMPLE_FINISH),
    .GOODNESS(GOODNESS), .GOODNESS_OUT(GOODNESS_OUT), .TS_CNT(TS_CNT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Source event stream and the handshake log it should produce.
  logic [11:0] src_addr[64];
  logic        src_last[64];
  int          src_n = 0;
  int          src_idx = 0;
  bit          src_fire = 0;
  logic [11:0] exp_log[64];
  int          exp_n = 0;

  task automatic push_ev(input logic [11:0] a, input logic l);
    src_addr[src_n] = a;
    src_last[src_n] = l;
    src_n++;
    if (a != 12'hFFF) begin exp_log[exp_n] = a; exp_n++; end
    if (l) begin exp_log[exp_n] = 12'hFFF; exp_n++; end
  endtask

  task automatic load_pattern(input int pat);
    src_n = 0; src_idx = 0; src_fire = 0; exp_n = 0;
    for (int s = 0; s < 8; s++) begin
      case (pat)
        0: begin push_ev(12'h005, 0); push_ev(12'h010, 0); push_ev(12'h30F, 1); end
        1: push_ev(12'hFFF, 1);
        default: begin push_ev(12'h001, 0); push_ev(12'hFFF, 0); push_ev(12'h7FE, 1); end
      endcase
    end
  endtask

  always begin
    @(posedge CLK); #2;
    if (src_fire) src_idx++;
    if (src_idx < src_n) begin
      EV_VALID = 1'b1; EV_ADDR = src_addr[src_idx]; EV_LAST = src_last[src_idx];
    end else begin
      EV_VALID = 1'b0; EV_ADDR = '0; EV_LAST = 1'b0;
    end
    src_fire = EV_VALID && EV_READY;
  end

  // Core model: ACK follows REQ two cycles later.
  bit   ack_en = 1;
  logic ack_d1 = 1'b0, ack_d2 = 1'b0;
  always begin
    @(posedge CLK); #2;
    if (!ack_en) begin
      ack_d1 = 1'b0; ack_d2 = 1'b0;
    end else begin
      ack_d2 = ack_d1; ack_d1 = AERIN_REQ;
    end
    AERIN_ACK = ack_d2;
  end

  // Handshake monitor.
  logic [11:0] hs_log[128];
  int          hs_n = 0, data_cnt = 0, mk_cnt = 0, stab_err = 0, done_cnt = 0;
  logic        prev_req = 1'b0;
  logic [11:0] prev_addr = '0;
  always begin
    @(posedge CLK); #1;
    if (AERIN_REQ && !prev_req) begin
      if (hs_n < 128) hs_log[hs_n] = AERIN_ADDR;
      hs_n++;
      if (AERIN_ADDR == 12'hFFF) mk_cnt++; else data_cnt++;
    end
    if (AERIN_REQ && prev_req && AERIN_ADDR != prev_addr) stab_err++;
    if (DONE) done_cnt++;
    prev_req = AERIN_REQ;
    prev_addr = AERIN_ADDR;
  end

  task automatic run_sample(input int pat, input bit pos, input bit train, input logic [31:0] g,
                            input int exp_data, input int exp_mk, input bit glitch, input string tag);
    int  mm;
    int  c;
    bit  glitched;
    load_pattern(pat);
    hs_n = 0; data_cnt = 0; mk_cnt = 0; stab_err = 0; done_cnt = 0;
    @(negedge CLK);
    START = 1'b1; IS_POS_IN = pos; IS_TRAIN_IN = train;
    @(negedge CLK);
    START = 1'b0;
    check({tag, "_start_busy"}, BUSY, 1);
    check({tag, "_start_is_pos"}, IS_POS, pos);
    check({tag, "_start_is_train"}, IS_TRAIN, train);
    check({tag, "_start_ts"}, TS_CNT, 0);
    check({tag, "_start_err"}, ERR, 0);
    glitched = 0; c = 0;
    while (TS_CNT != 4'd8 && c < 3000) begin
      @(negedge CLK);
      c++;
      START = 1'b0; ONE_SAMPLE_FINISH = 1'b0; IS_POS_IN = pos; GOODNESS = '0;
      if (glitch && !glitched && TS_CNT == 4'd3) begin
        START = 1'b1; ONE_SAMPLE_FINISH = 1'b1; IS_POS_IN = !pos; GOODNESS = 32'hBAD0_0BAD;
        glitched = 1;
      end
    end
    START = 1'b0; ONE_SAMPLE_FINISH = 1'b0;
    check({tag, "_ts_reached"}, TS_CNT, 8);
    repeat (3) @(negedge CLK);
    check({tag, "_wait_busy"}, BUSY, 1);
    check({tag, "_wait_ready"}, EV_READY, 0);
    check({tag, "_wait_done"}, DONE, 0);
    check({tag, "_wait_is_pos"}, IS_POS, pos);
    ONE_SAMPLE_FINISH = 1'b1; GOODNESS = g;
    @(negedge CLK);
    ONE_SAMPLE_FINISH = 1'b0; GOODNESS = '0;
    check({tag, "_done_pulse"}, DONE, 1);
    check({tag, "_goodness_out"}, GOODNESS_OUT, g);
    check({tag, "_idle_busy"}, BUSY, 0);
    @(negedge CLK);
    check({tag, "_done_low"}, DONE, 0);
    repeat (2) @(negedge CLK);
    check({tag, "_data_hs"}, data_cnt, exp_data);
    check({tag, "_marker_hs"}, mk_cnt, exp_mk);
    check({tag, "_hs_total"}, hs_n, exp_n);
    mm = 0;
    for (int i = 0; i < exp_n && i < 128; i++) if (hs_log[i] !== exp_log[i]) mm++;
    check({tag, "_hs_order_mismatches"}, mm, 0);
    check({tag, "_addr_stable_violations"}, stab_err, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_glitch_applied"}, glitched, glitch);
    $display("sample %s: data=%0d markers=%0d ts=%0d goodness_out=%h", tag, data_cnt, mk_cnt, TS_CNT, GOODNESS_OUT);
  endtask

  typedef struct {
    int          pat;
    bit          pos;
    bit          train;
    logic [31:0] good;
    int          exp_data;
    int          exp_mk;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int cnt;
    vecs[0] = '{pat: 0, pos: 1, train: 0, good: 32'h0000_1234, exp_data: 24, exp_mk: 8};
    vecs[1] = '{pat: 1, pos: 0, train: 1, good: 32'hDEAD_BEEF, exp_data: 0,  exp_mk: 8};
    vecs[2] = '{pat: 2, pos: 1, train: 1, good: 32'hA5A5_0001, exp_data: 16, exp_mk: 8};

    repeat (3) @(negedge CLK);
    check("reset_req", AERIN_REQ, 0);
    check("reset_busy", BUSY, 0);
    check("reset_ready", EV_READY, 0);
    check("reset_ts", TS_CNT, 0);
    check("reset_err_done", {ERR, DONE}, 0);
    check("reset_goodness_out", GOODNESS_OUT, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 3; i++)
      run_sample(vecs[i].pat, vecs[i].pos, vecs[i].train, vecs[i].good,
                 vecs[i].exp_data, vecs[i].exp_mk, 0, $sformatf("vec%0d", i));

    // ACK never arrives: watchdog aborts the first data handshake.
    load_pattern(0);
    ack_en = 0; done_cnt = 0;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    cnt = 0;
    while (!AERIN_REQ && cnt < 50) begin @(negedge CLK); cnt++; end
    check("timeout_req_seen", AERIN_REQ, 1);
    cnt = 0;
    while (AERIN_REQ && cnt < 100) begin @(negedge CLK); cnt++; end
    check("timeout_req_cycles", cnt, 16);
    check("timeout_err", ERR, 1);
    check("timeout_busy", BUSY, 0);
    repeat (3) @(negedge CLK);
    check("timeout_err_sticky", ERR, 1);
    check("timeout_no_done", done_cnt, 0);
    $display("timeout: req_cycles=%0d err=%0d busy=%0d", cnt, ERR, BUSY);
    ack_en = 1;
    repeat (3) @(negedge CLK);

    // START and FINISH while busy are ignored; START also clears the sticky ERR.
    run_sample(0, 0, 1, 32'h0F0F_F0F0, 24, 8, 1, "glitch");

    // Reset in the middle of a handshake.
    load_pattern(0);
    @(negedge CLK); START = 1'b1; IS_POS_IN = 1'b1; IS_TRAIN_IN = 1'b1;
    @(negedge CLK); START = 1'b0;
    cnt = 0;
    while (!AERIN_REQ && cnt < 50) begin @(negedge CLK); cnt++; end
    check("rst_mid_req_seen", AERIN_REQ, 1);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_req", AERIN_REQ, 0);
    check("rst_mid_addr", AERIN_ADDR, 0);
    check("rst_mid_flags", {EV_READY, BUSY, DONE, ERR, IS_POS, IS_TRAIN}, 0);
    check("rst_mid_ts", TS_CNT, 0);
    check("rst_mid_goodness_out", GOODNESS_OUT, 0);
    $display("reset mid-handshake: req=%0d busy=%0d addr=%h", AERIN_REQ, BUSY, AERIN_ADDR);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    run_sample(0, 1, 0, 32'h0000_1234, 24, 8, 0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
